// File: rtl/serial_word_assembler_pkg.sv
// Shared types for the serial word assembler.
// State encoding and the word widths of the downstream register arrays.
`ifndef SERIAL_WORD_ASSEMBLER_PKG_SV
`define SERIAL_WORD_ASSEMBLER_PKG_SV
package serial_word_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10
  } sa_state_t;

  localparam int WIDTH_WIDE   = 32;
  localparam int WIDTH_NARROW = 22;

endpackage
`endif

// File: rtl/serial_word_assembler_bit_counter.sv
// Bit counter for the serial word assembler.
// Clear wins over enable; tc flags the last bit of a word.
module bit_counter
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = WIDTH_WIDE,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler driving a register array load port.
// Only complete words ever produce a load strobe.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH     = WIDTH_WIDE,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic [7:0]       word_count
);

  sa_state_t        state;
  sa_state_t        state_nx;
  logic             cnt_clr;
  logic             cnt_en;
  logic             tc;
  logic             take;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // abort outranks a same-cycle bit; start is only honoured in IDLE/LOAD
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          cnt_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else if (ser_valid) begin
          take = 1'b1;
          if (tc) begin
            state_nx = LOAD;
            cnt_clr  = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      LOAD: begin
        state_nx = start ? SHIFT : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], ser_data}
                             : {ser_data, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (take) begin
      shreg <= shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (state == LOAD) begin
      word_count <= word_count + 8'd1;
    end
  end

  assign ser_ready = (state == SHIFT);
  assign load      = (state == LOAD);
  assign busy      = (state != IDLE);
  assign data_out  = shreg;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: 32-bit MSB-first and 22-bit LSB-first.
// Each instance feeds a downstream load-enabled register.
module tb_serial_word_assembler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, abort_a, sv_a, sd_a;
  logic        rdy_a, load_a, busy_a;
  logic [31:0] dout_a;
  logic [7:0]  wc_a;

  logic        start_b, abort_b, sv_b, sd_b;
  logic        rdy_b, load_b, busy_b;
  logic [21:0] dout_b;
  logic [7:0]  wc_b;

  serial_word_assembler #(
    .WIDTH(32), .MSB_FIRST(1'b1), .CNT_W(6)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .ser_valid(sv_a), .ser_data(sd_a), .ser_ready(rdy_a),
    .data_out(dout_a), .load(load_a), .busy(busy_a),
    .word_count(wc_a)
  );

  serial_word_assembler #(
    .WIDTH(22), .MSB_FIRST(1'b0), .CNT_W(6)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .ser_valid(sv_b), .ser_data(sd_b), .ser_ready(rdy_b),
    .data_out(dout_b), .load(load_b), .busy(busy_b),
    .word_count(wc_b)
  );

  // downstream enabled register arrays
  logic [31:0] reg_a;
  logic [21:0] reg_b;
  always_ff @(posedge clk) if (load_a) reg_a <= dout_a;
  always_ff @(posedge clk) if (load_b) reg_b <= dout_b;

  int loads_a = 0;
  always @(negedge clk) if (load_a === 1'b1) loads_a++;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic frame_a(input logic [31:0] w, input bit gapped,
                         input bit hold, output int lat);
    int i, k;
    bit acc;
    i = 0; k = 0; lat = 0;
    start_a = 1'b1;
    @(negedge clk); lat++;
    start_a = hold;
    while (i < 32 && k < 200) begin
      sv_a = !(gapped && (k % 3 == 2));
      sd_a = w[31-i];
      acc  = sv_a && rdy_a;
      @(negedge clk); lat++; k++;
      if (acc) i++;
    end
    sv_a = 1'b0;
  endtask

  task automatic frame_b(input logic [21:0] w, input bit hold,
                         output int lat);
    int i, k;
    bit acc;
    i = 0; k = 0; lat = 0;
    start_b = 1'b1;
    @(negedge clk); lat++;
    start_b = hold;
    while (i < 22 && k < 200) begin
      sv_b = 1'b1;
      sd_b = w[i];
      acc  = rdy_b;
      @(negedge clk); lat++; k++;
      if (acc) i++;
    end
    sv_b = 1'b0;
  endtask

  initial begin : main
    int          lat, wcm, base, ab, k;
    bit          acc, bv;
    bit          q[$];
    logic [31:0] w, exp, saved;
    logic [21:0] wb;

    rst = 1'b1;
    start_a = 0; abort_a = 0; sv_a = 0; sd_a = 0;
    start_b = 0; abort_b = 0; sv_b = 0; sd_b = 0;
    @(negedge clk);
    chk("rst_dout", dout_a, 32'h0);
    chk("rst_load", load_a, 1'b0);
    chk("rst_ready", rdy_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_wc", wc_a, 8'd0);
    chk("rst_dout_b", dout_b, 22'h0);
    rst = 1'b0;
    @(negedge clk);

    // full word
    frame_a(32'hA5A5_0F0F, 1'b0, 1'b0, lat);
    chk("full_lat", lat, 33);
    chk("full_load", load_a, 1'b1);
    chk("full_data", dout_a, 32'hA5A5_0F0F);
    @(negedge clk);
    chk("full_load_off", load_a, 1'b0);
    chk("full_reg", reg_a, 32'hA5A5_0F0F);
    chk("full_wc", wc_a, 8'd1);
    chk("full_idle", busy_a, 1'b0);

    // gapped: 32 bits at 2 of every 3 cycles -> 15 gaps
    frame_a(32'hA5A5_0F0F, 1'b1, 1'b0, lat);
    chk("gap_lat", lat, 33 + 15);
    chk("gap_load", load_a, 1'b1);
    chk("gap_data", dout_a, 32'hA5A5_0F0F);
    @(negedge clk);
    chk("gap_wc", wc_a, 8'd2);

    // reset mid-frame
    saved = reg_a;
    base  = loads_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sv_a = 1'b1; sd_a = 1'($urandom);
      @(negedge clk);
    end
    sv_a = 1'b0;
    chk("mid_busy", busy_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dout", dout_a, 32'h0);
    chk("mid_rst_ready", rdy_a, 1'b0);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_wc", wc_a, 8'd0);
    chk("mid_rst_load", load_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_no_load", loads_a, base);
    chk("mid_reg_kept", reg_a, saved);

    // abort together with a valid bit after 16 bits
    base = loads_a;
    exp  = 32'h0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bv = 1'($urandom);
      sv_a = 1'b1; sd_a = bv;
      exp = exp * 2 + 32'(bv);
      @(negedge clk);
    end
    abort_a = 1'b1; sv_a = 1'b1; sd_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0; sv_a = 1'b0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_ready", rdy_a, 1'b0);
    chk("abort_partial", dout_a, exp);
    repeat (40) @(negedge clk);
    chk("abort_no_load", loads_a, base);
    chk("abort_wc", wc_a, 8'd0);
    chk("abort_reg", reg_a, saved);

    // back-to-back with start held
    frame_a(32'h0000_0001, 1'b0, 1'b1, lat);
    chk("b2b0_lat", lat, 33);
    chk("b2b0_data", dout_a, 32'h0000_0001);
    chk("b2b0_load", load_a, 1'b1);
    frame_a(32'hFFFF_FFFF, 1'b0, 1'b1, lat);
    chk("b2b1_lat", lat, 33);
    chk("b2b1_data", dout_a, 32'hFFFF_FFFF);
    chk("b2b1_reg", reg_a, 32'h0000_0001);
    frame_a(32'h8000_0000, 1'b0, 1'b0, lat);
    chk("b2b2_lat", lat, 33);
    chk("b2b2_data", dout_a, 32'h8000_0000);
    chk("b2b2_reg", reg_a, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("b2b_wc", wc_a, 8'd3);
    chk("b2b_reg", reg_a, 32'h8000_0000);

    // random frames; model keeps the accepted bits and forms the word
    wcm = 3;
    for (int f = 0; f < 24; f++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      q.delete();
      k = 0;
      base  = loads_a;
      saved = reg_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      while (q.size() < 32 && k < 400) begin
        if (q.size() == ab) begin
          abort_a = 1'b1; sv_a = 1'b1; sd_a = 1'($urandom);
          @(negedge clk);
          abort_a = 1'b0;
          break;
        end
        sv_a = ($urandom_range(0, 3) != 0);
        sd_a = 1'($urandom);
        acc  = sv_a && rdy_a;
        bv   = sd_a;
        @(negedge clk); k++;
        if (acc) q.push_back(bv);
      end
      sv_a = 1'b0;
      exp = 32'h0;
      foreach (q[i]) exp = exp * 2 + 32'(q[i]);
      if (ab >= 0) begin
        chk("rnd_abort_busy", busy_a, 1'b0);
        repeat (2) @(negedge clk);
        chk("rnd_abort_noload", loads_a, base);
        chk("rnd_abort_reg", reg_a, saved);
      end else begin
        chk("rnd_load", load_a, 1'b1);
        chk("rnd_data", dout_a, exp);
        wcm = (wcm + 1) % 256;
        @(negedge clk);
        chk("rnd_reg", reg_a, exp);
      end
      chk("rnd_wc", wc_a, 8'(wcm));
    end

    // 22-bit LSB-first
    frame_b(22'h2A_AAAA, 1'b0, lat);
    chk("b_lat", lat, 23);
    chk("b_load", load_b, 1'b1);
    chk("b_data", dout_b, 22'h2A_AAAA);
    @(negedge clk);
    chk("b_reg", reg_b, 22'h2A_AAAA);
    chk("b_wc", wc_b, 8'd1);

    // 255 more words: word_count wraps to 0
    for (int n = 0; n < 255; n++) begin
      wb = 22'($urandom);
      frame_b(wb, 1'b1, lat);
      chk("b_wrap_data", dout_b, wb);
      if (n == 254) chk("b_wrap_wc_pre", wc_b, 8'd255);
    end
    start_b = 1'b0;
    @(negedge clk);
    chk("b_wrap_wc", wc_b, 8'd0);
    chk("b_wrap_idle", busy_b, 1'b0);
    chk("b_wrap_reg", reg_b, wb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
